// File: rtl/nr_div_pkg.sv
// Shared definitions for the non-restoring divider.
//   state_t   : FSM states (IDLE, CALC, FIX, DONE)
//   DEF_WIDTH : default operand/result width
//   cnt_w()   : width of the iteration counter for a given operand width
package nr_div_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/nr_divider_if.sv
// Request/result bundle of the divider.
//   master : drives start, dividend, divisor; observes the results
//   slave  : the divider side (quotient, remainder, busy, done, dz, ovf)
interface nr_divider_if
    import nr_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             dz;
    logic             ovf;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, dz, ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, dz, ovf
    );

endinterface

// File: rtl/nr_div_step.sv
// One combinational non-restoring iteration.
//   rem    : partial remainder (WIDTH+1 bits, two's complement)
//   quo    : quotient/dividend shift register; its MSB feeds the remainder
//   dvs    : divisor magnitude
//   rem_nx : next partial remainder
//   quo_nx : next quotient, new bit = inverted sign of rem_nx
module nr_div_step
    import nr_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic signed [WIDTH:0]   rem,
    input  logic        [WIDTH-1:0] quo,
    input  logic        [WIDTH-1:0] dvs,
    output logic signed [WIDTH:0]   rem_nx,
    output logic        [WIDTH-1:0] quo_nx
);

    logic signed [WIDTH:0] rem_sh;
    logic signed [WIDTH:0] dvs_ext;

    always_comb begin
        rem_sh  = {rem[WIDTH-1:0], quo[WIDTH-1]};
        dvs_ext = {1'b0, dvs};
        // The true result always lies in [-dvs, dvs), so wrapping in the
        // intermediate shift is harmless under modular arithmetic.
        rem_nx  = rem[WIDTH] ? (rem_sh + dvs_ext) : (rem_sh - dvs_ext);
        quo_nx  = {quo[WIDTH-2:0], ~rem_nx[WIDTH]};
    end

endmodule

// File: rtl/nr_divider.sv
// Multi-cycle non-restoring divider.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of nr_divider_if (start/dividend/divisor in,
//              quotient/remainder/busy/done/dz/ovf out)
// Optional feature macro NR_DIVIDER_SIGNED_EN: two's complement operands
// with truncation toward zero; without it operands are unsigned and ovf is 0.
module nr_divider
    import nr_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic         clk,
    input logic         rst,
    nr_divider_if.slave bus
);

    localparam int CW = cnt_w(WIDTH);

    state_t state, state_nx;
    logic [CW-1:0] cnt;

    logic signed [WIDTH:0]   prem, prem_nx;
    logic        [WIDTH-1:0] qacc, qacc_nx;
    logic        [WIDTH-1:0] dvs;
    logic        [WIDTH-1:0] rem_fix;

    logic [WIDTH-1:0] quo_r, rem_r;
    logic             dz_r;
    logic             busy, done;

`ifdef NR_DIVIDER_SIGNED_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic neg_q, neg_r, ovf_pend, ovf_r;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic n);
        return n ? -v : v;
    endfunction
`endif

    nr_div_step #(.WIDTH(WIDTH)) u_step (
        .rem    (prem),
        .quo    (qacc),
        .dvs    (dvs),
        .rem_nx (prem_nx),
        .quo_nx (qacc_nx)
    );

    // Final correction only needs WIDTH bits: the corrected value is in [0, dvs).
    assign rem_fix = prem[WIDTH] ? (prem[WIDTH-1:0] + dvs) : prem[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = (bus.divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    state_nx = FIX;
                end
            end
            FIX: begin
                state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

    // Control and visible results: cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            quo_r <= '0;
            rem_r <= '0;
            dz_r  <= 1'b0;
`ifdef NR_DIVIDER_SIGNED_EN
            ovf_r <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.start) begin
                        dz_r <= 1'b0;
`ifdef NR_DIVIDER_SIGNED_EN
                        ovf_r <= 1'b0;
`endif
                        if (bus.divisor == '0) begin
                            dz_r  <= 1'b1;
                            quo_r <= '1;
                            rem_r <= bus.dividend;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    cnt <= '0;
`ifdef NR_DIVIDER_SIGNED_EN
                    quo_r <= apply_sign(qacc, neg_q);
                    rem_r <= apply_sign(rem_fix, neg_r);
                    ovf_r <= ovf_pend;
`else
                    quo_r <= qacc;
                    rem_r <= rem_fix;
`endif
                end
                DONE: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // Working datapath: loaded at accept, iterated in CALC, no reset needed.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            prem <= '0;
`ifdef NR_DIVIDER_SIGNED_EN
            qacc     <= mag(bus.dividend);
            dvs      <= mag(bus.divisor);
            neg_q    <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            neg_r    <= bus.dividend[WIDTH-1];
            ovf_pend <= (bus.dividend == MOST_NEG) && (bus.divisor == '1);
`else
            qacc <= bus.dividend;
            dvs  <= bus.divisor;
`endif
        end else if (state == CALC) begin
            prem <= prem_nx;
            qacc <= qacc_nx;
        end
    end

    assign bus.quotient  = quo_r;
    assign bus.remainder = rem_r;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.dz        = dz_r;
`ifdef NR_DIVIDER_SIGNED_EN
    assign bus.ovf       = ovf_r;
`else
    assign bus.ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_nr_divider.sv
// Directed bench for nr_divider at WIDTH=4. Latency is counted in clock
// edges from the edge that samples start (that edge counts as 1).
// Expectations follow NR_DIVIDER_SIGNED_EN when it is defined.
module tb_nr_divider;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    nr_divider_if #(.WIDTH(4)) bus ();

    nr_divider #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Issue one division (called #1 after a rising edge) and check results.
    // With intrude set, a 5/5 start is pushed while the first op is in CALC.
    task automatic run_div(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] eq, input logic [3:0] er,
                           input logic edz, input logic eovf, input int elat,
                           input bit intrude);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        while (!seen && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) bus.start = 1'b0;
            if (intrude) begin
                if (lat == 1) begin
                    bus.start    = 1'b1;
                    bus.dividend = 4'd5;
                    bus.divisor  = 4'd5;
                end
                if (lat == 2) chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
                if (lat == 3) bus.start = 1'b0;
            end
            if (bus.done) seen = 1'b1;
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        chk({tag, "_q"}, 32'(bus.quotient), 32'(eq));
        chk({tag, "_r"}, 32'(bus.remainder), 32'(er));
        chk({tag, "_dz"}, 32'(bus.dz), 32'(edz));
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eovf));
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
        chk({tag, "_hold"}, 32'(bus.quotient), 32'(eq));
    endtask

    initial begin
        int  lat;
        bit  seen;
        bit  anydone;

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q",    32'(bus.quotient),  32'd0);
        chk("rst_r",    32'(bus.remainder), 32'd0);
        chk("rst_busy", 32'(bus.busy),      32'd0);
        chk("rst_done", 32'(bus.done),      32'd0);
        chk("rst_dz",   32'(bus.dz),        32'd0);
        chk("rst_ovf",  32'(bus.ovf),       32'd0);

        // Start on the very first edge after reset release
        rst = 1'b0;
`ifdef NR_DIVIDER_SIGNED_EN
        run_div("d13_3", 4'd13, 4'd3, 4'b1111, 4'd0, 1'b0, 1'b0, 6, 1'b0);   // -3/3
`else
        run_div("d13_3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1'b0, 6, 1'b0);
`endif
        run_div("d7_0", 4'd7, 4'd0, 4'b1111, 4'b0111, 1'b1, 1'b0, 1, 1'b0);

`ifdef NR_DIVIDER_SIGNED_EN
        run_div("d9_2i", 4'd9, 4'd2, 4'b1101, 4'b1111, 1'b0, 1'b0, 6, 1'b1); // -7/2
        run_div("dm7_2", 4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0, 1'b0, 6, 1'b0);
        run_div("dm8_m1", 4'b1000, 4'b1111, 4'b1000, 4'd0, 1'b0, 1'b1, 6, 1'b0);
        run_div("d7_m2", 4'd7, 4'b1110, 4'b1101, 4'd1, 1'b0, 1'b0, 6, 1'b0);
        run_div("dm8_1", 4'b1000, 4'd1, 4'b1000, 4'd0, 1'b0, 1'b0, 6, 1'b0);
        run_div("d5_3", 4'd5, 4'd3, 4'd1, 4'd2, 1'b0, 1'b0, 6, 1'b0);
        run_div("dm1_0", 4'b1111, 4'd0, 4'b1111, 4'b1111, 1'b1, 1'b0, 1, 1'b0);
`else
        run_div("d9_2i", 4'd9, 4'd2, 4'd4, 4'd1, 1'b0, 1'b0, 6, 1'b1);
        run_div("d15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 1'b0, 6, 1'b0);
        run_div("d15_15", 4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 1'b0, 6, 1'b0);
        run_div("d0_5", 4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 6, 1'b0);
        run_div("d3_7", 4'd3, 4'd7, 4'd0, 4'd3, 1'b0, 1'b0, 6, 1'b0);
        run_div("d14_4", 4'd14, 4'd4, 4'd3, 4'd2, 1'b0, 1'b0, 6, 1'b0);
        run_div("d15_0", 4'd15, 4'd0, 4'b1111, 4'b1111, 1'b1, 1'b0, 1, 1'b0);
`endif

        // Start raised while done is high is only taken after IDLE
        bus.dividend = 4'd15;
        bus.divisor  = 4'd1;
        bus.start    = 1'b1;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) bus.start = 1'b0;
            if (bus.done) seen = 1'b1;
        end
        chk("chain_first", 32'(seen), 32'd1);
        bus.dividend = 4'd6;
        bus.divisor  = 4'd3;
        bus.start    = 1'b1;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 2) bus.start = 1'b0;
            if (bus.done) seen = 1'b1;
        end
        chk("chain_seen", 32'(seen), 32'd1);
        chk("chain_lat", 32'(lat), 32'd7);
        chk("chain_q", 32'(bus.quotient), 32'd2);
        chk("chain_r", 32'(bus.remainder), 32'd0);
        @(posedge clk); #1;

        // Reset in the 3rd CALC cycle aborts without a done pulse
        run_div("d7_0b", 4'd7, 4'd0, 4'b1111, 4'b0111, 1'b1, 1'b0, 1, 1'b0);
        bus.dividend = 4'd9;
        bus.divisor  = 4'd2;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_q",    32'(bus.quotient),  32'd0);
        chk("arst_r",    32'(bus.remainder), 32'd0);
        chk("arst_busy", 32'(bus.busy),      32'd0);
        chk("arst_done", 32'(bus.done),      32'd0);
        chk("arst_dz",   32'(bus.dz),        32'd0);
        chk("arst_ovf",  32'(bus.ovf),       32'd0);
        anydone = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 1) rst = 1'b0;
            if (bus.done) anydone = 1'b1;
        end
        chk("arst_nodone", 32'(anydone), 32'd0);
        chk("arst_idle", 32'(bus.busy), 32'd0);
        run_div("d6_3", 4'd6, 4'd3, 4'd2, 4'd0, 1'b0, 1'b0, 6, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nr_divider.md
NR_DIVIDER -- requirements
Module: nr_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand and result width in bits (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 SHALL have port dividend, input, WIDTH bits: numerator, captured when start is accepted.
REQ-006 SHALL have port divisor, input, WIDTH bits: denominator, captured when start is accepted.
REQ-007 SHALL have port quotient, output, WIDTH bits: result quotient.
REQ-008 SHALL have port remainder, output, WIDTH bits: result remainder.
REQ-009 SHALL have port busy, output, 1 bit: high while a division is in progress, in every state except IDLE.
REQ-010 SHALL have port done, output, 1 bit: single-cycle pulse marking valid results.
REQ-011 SHALL have port dz, output, 1 bit: divide-by-zero flag for the last operation.
REQ-012 SHALL have port ovf, output, 1 bit: signed overflow flag (most-negative / -1) for the last operation.

Function
REQ-013 SHALL implement an FSM with states IDLE, CALC, FIX and DONE.
REQ-014 SHALL, on an edge in IDLE with start=1, capture both operands, clear dz and ovf, and enter CALC with the iteration counter at 0.
REQ-015 SHALL, if the captured divisor is 0, skip CALC and FIX: go IDLE->DONE with dz=1, quotient=all ones, remainder=dividend.
REQ-016 SHALL perform one non-restoring step per CALC cycle on operand magnitudes, for exactly WIDTH cycles: shift the partial remainder left, add the divisor if the remainder is negative, otherwise subtract it, and set the quotient bit to the inverted remainder sign.
REQ-017 SHALL hold the partial remainder in WIDTH+1 bits, so that no step overflows.
REQ-018 SHALL, in FIX (one cycle), add the divisor back once if the remainder is negative, then apply result signs: quotient negated if the operand signs differ, remainder takes the dividend sign (truncation toward zero).
REQ-019 SHALL, in DONE, assert done for exactly one cycle, then return to IDLE.
REQ-020 SHALL pulse done WIDTH+2 edges after the accepting edge for a nonzero divisor, and 1 edge after it for a zero divisor.
REQ-021 SHALL hold quotient, remainder, dz and ovf stable from DONE until the next accepted start.
REQ-022 SHALL ignore start while busy=1, with no effect on the operation in flight.
REQ-023 SHALL accept a start asserted in the same cycle that done is high only after returning to IDLE; it is not queued.
REQ-024 SHALL, for most-negative / -1, set ovf=1, quotient=most-negative (wrapped) and remainder=0.

Reset
REQ-025 SHALL, on rst=1 at any time including mid-operation, immediately force: state=IDLE, quotient=0, remainder=0, busy=0, done=0, dz=0, ovf=0, counter=0.
REQ-026 SHALL NOT emit a done pulse for an operation aborted by reset.
REQ-027 SHALL accept start on the first edge after rst is released.

Configuration
REQ-028 SHALL, when macro NR_DIVIDER_SIGNED_EN is defined, treat operands as two's complement and apply the sign handling of REQ-018 and REQ-024.
REQ-029 SHALL, when NR_DIVIDER_SIGNED_EN is undefined, treat operands as unsigned, remove the sign-handling logic, and tie ovf to 0; FIX then performs only the remainder correction.

Structure
REQ-030 SHALL place the FSM state enum, the default WIDTH constant and a counter-width helper ($clog2(WIDTH+1)) in shared package nr_div_pkg.
REQ-031 SHALL implement one combinational sub-module, nr_div_step: a single add/subtract-and-shift iteration with inputs partial remainder, quotient and divisor, and outputs for the next partial remainder and quotient; instantiated once in nr_divider.

Verification (WIDTH=4)
REQ-032 SHALL cover, unsigned build: 13/3 -> done 6 edges after start, quotient=4, remainder=1, dz=0.
REQ-033 SHALL cover, signed build: -7/2 (4'b1001/4'b0010) -> quotient=4'b1101 (-3), remainder=4'b1111 (-1).
REQ-034 SHALL cover, signed build: -8/-1 -> ovf=1, quotient=4'b1000, remainder=0.
REQ-035 SHALL cover 7/0 -> done 1 edge after start, dz=1, quotient=4'b1111, remainder=4'b0111.
REQ-036 SHALL cover start 9/2, then start 5/5 asserted mid-CALC -> the second start is ignored; result quotient=4, remainder=1.
REQ-037 SHALL cover rst asserted in the 3rd CALC cycle -> all outputs 0 in the same cycle, no done; then 6/3 -> quotient=2, remainder=0.
